// File: rtl/stage_memory_mc.sv
// rtl/stage_memory_mc.sv - multicycle memory stage with req/gnt/rvalid bus handshake
package selector;
    typedef enum logic [2:0] {
        RD_BYTE        = 3'd0,
        RD_HALF        = 3'd1,
        RD_UNSIGN_HALF = 3'd2,
        RD_WORD        = 3'd3,
        RD_LWL         = 3'd4,
        RD_LWR         = 3'd5
    } mem_read_type;

    typedef enum logic [2:0] {
        WR_BYTE = 3'd0,
        WR_HALF = 3'd1,
        WR_WORD = 3'd2,
        WR_SWL  = 3'd3,
        WR_SWR  = 3'd4
    } mem_write_type;
endpackage

module stage_memory_mc #(
    parameter int N       = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           read_mem,
    input  logic                           write_mem,
    input  selector::mem_read_type         read_mode,
    input  selector::mem_write_type        write_mode,
    input  logic [N-1:0]                   addr_in,
    input  logic [N-1:0]                   data_in,
    output logic [N-1:0]                   data_out,
    output logic                           busy,
    output logic                           done,
    output logic                           addr_error,
    output logic                           bus_error,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [N-$clog2(N/8)-1:0]       mem_addr,
    output logic [N/8-1:0]                 mem_mask,
    output logic [N-1:0]                   mem_wdata,
    input  logic                           mem_gnt,
    input  logic                           mem_rvalid,
    input  logic [N-1:0]                   mem_rdata
);
    import selector::*;

    localparam int NB = N / 8;
    localparam int IW = $clog2(NB);
    localparam int SW = IW + 4;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q;
    mem_read_type  rmode_q;
    logic [N-1:0]  d_q;
    logic [CW-1:0] cnt_q;
    logic          addr_err_q;
    logic          bus_err_q;

    logic          accept;
    logic          acc_bad;
    logic [IW-1:0] acc_idx;
    logic [IW-1:0] acc_rev;
    logic [SW-1:0] acc_idx_sh;
    logic [SW-1:0] acc_rev_sh;
    logic [NB-1:0] acc_mask;
    logic [N-1:0]  acc_wdata;

    logic [SW-1:0] idx_sh;
    logic [SW-1:0] lwl_keep_sh;
    logic [SW-1:0] lwl_sh;
    logic [N-1:0]  rsh;
    logic [N-1:0]  rd_fmt;
    logic          timeout_hit;

    assign acc_idx     = addr_in[IW-1:0];
    assign acc_rev     = IW'(NB - 1) - acc_idx;
    assign acc_idx_sh  = SW'({acc_idx, 3'b000});
    assign acc_rev_sh  = SW'({acc_rev, 3'b000});
    assign accept      = ((state_q == IDLE) || (state_q == DONE)) && start && (read_mem || write_mem);
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    assign busy       = (state_q == REQ) || (state_q == WAIT);
    assign done       = (state_q == DONE);
    assign mem_req    = (state_q == REQ);
    assign addr_error = (state_q == DONE) && addr_err_q;
    assign bus_error  = (state_q == DONE) && bus_err_q;

    // Alignment and mode validity of the access being presented; stores win over loads
    always_comb begin
        acc_bad = 1'b0;
        if (write_mem) begin
            case (write_mode)
                WR_HALF:                   acc_bad = acc_idx[0];
                WR_WORD:                   acc_bad = |acc_idx;
                WR_BYTE, WR_SWL, WR_SWR:   acc_bad = 1'b0;
                default:                   acc_bad = 1'b1;
            endcase
        end else begin
            case (read_mode)
                RD_HALF, RD_UNSIGN_HALF:   acc_bad = acc_idx[0];
                RD_WORD:                   acc_bad = |acc_idx;
                RD_BYTE, RD_LWL, RD_LWR:   acc_bad = 1'b0;
                default:                   acc_bad = 1'b1;
            endcase
        end
    end

    // Lane enables and lane-positioned store data, computed once at accept time
    always_comb begin
        acc_mask  = {NB{1'b1}};
        acc_wdata = data_in;
        if (write_mem) begin
            case (write_mode)
                WR_BYTE: begin
                    acc_mask  = NB'(1) << acc_idx;
                    acc_wdata = {NB{data_in[7:0]}};
                end
                WR_HALF: begin
                    acc_mask  = NB'(3) << acc_idx;
                    acc_wdata = {(NB/2){data_in[15:0]}};
                end
                WR_SWL: begin
                    acc_mask  = {NB{1'b1}} >> acc_rev;
                    acc_wdata = data_in >> acc_rev_sh;
                end
                WR_SWR: begin
                    acc_mask  = {NB{1'b1}} << acc_idx;
                    acc_wdata = data_in << acc_idx_sh;
                end
                default: begin
                    acc_mask  = {NB{1'b1}};
                    acc_wdata = data_in;
                end
            endcase
        end
    end

    assign idx_sh      = SW'({idx_q, 3'b000});
    assign lwl_keep_sh = idx_sh + SW'(8);
    assign lwl_sh      = SW'(8 * (NB - 1)) - idx_sh;
    assign rsh         = mem_rdata >> idx_sh;

    // Load formatting of the returned word using the registered lane index and old rt value
    always_comb begin
        rd_fmt = mem_rdata;
        case (rmode_q)
            RD_BYTE:        rd_fmt = {{(N-8){rsh[7]}}, rsh[7:0]};
            RD_HALF:        rd_fmt = {{(N-16){rsh[15]}}, rsh[15:0]};
            RD_UNSIGN_HALF: rd_fmt = {{(N-16){1'b0}}, rsh[15:0]};
            RD_WORD:        rd_fmt = mem_rdata;
            RD_LWL:         rd_fmt = (d_q & ({N{1'b1}} >> lwl_keep_sh)) | (mem_rdata << lwl_sh);
            RD_LWR:         rd_fmt = (d_q & ~({N{1'b1}} >> idx_sh)) | (mem_rdata >> idx_sh);
            default:        rd_fmt = mem_rdata;
        endcase
    end

    // Next-state logic for the bus transaction
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    state_d = acc_bad ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d = mem_we ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid || timeout_hit) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Access capture, bus request registers, wait counter, and result/error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q      <= '0;
            rmode_q    <= RD_BYTE;
            d_q        <= '0;
            cnt_q      <= '0;
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
            data_out   <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_mask   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        idx_q      <= acc_idx;
                        rmode_q    <= read_mode;
                        d_q        <= data_in;
                        addr_err_q <= acc_bad;
                        bus_err_q  <= 1'b0;
                        if (!acc_bad) begin
                            mem_we    <= write_mem;
                            mem_addr  <= addr_in[N-1:IW];
                            mem_mask  <= acc_mask;
                            mem_wdata <= acc_wdata;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        cnt_q <= '0;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        data_out <= rd_fmt;
                    end else if (timeout_hit) begin
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_memory_mc.sv
// tb/tb_stage_memory_mc.sv - self-checking bench for stage_memory_mc
module tb_stage_memory_mc;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, read_mem, write_mem;
    selector::mem_read_type  read_mode;
    selector::mem_write_type write_mode;
    logic [31:0] addr_in, data_in, data_out, mem_wdata, mem_rdata;
    logic        busy, done, addr_error, bus_error, mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [29:0] mem_addr;
    logic [3:0]  mem_mask;

    logic        start_w, read_mem_w, write_mem_w;
    selector::mem_read_type  read_mode_w;
    selector::mem_write_type write_mode_w;
    logic [63:0] addr_in_w, data_in_w, data_out_w, mem_wdata_w, mem_rdata_w;
    logic        busy_w, done_w, addr_error_w, bus_error_w, mem_req_w, mem_we_w, mem_gnt_w, mem_rvalid_w;
    logic [60:0] mem_addr_w;
    logic [7:0]  mem_mask_w;

    int tests = 0;
    int fails = 0;
    logic [31:0] last_dout;

    always #5 clk = ~clk;

    stage_memory_mc #(.N(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .read_mem(read_mem), .write_mem(write_mem),
        .read_mode(read_mode), .write_mode(write_mode), .addr_in(addr_in), .data_in(data_in),
        .data_out(data_out), .busy(busy), .done(done), .addr_error(addr_error), .bus_error(bus_error),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_mask(mem_mask),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    stage_memory_mc #(.N(64), .TIMEOUT(TMO)) dut_w (
        .clk(clk), .reset(reset), .start(start_w), .read_mem(read_mem_w), .write_mem(write_mem_w),
        .read_mode(read_mode_w), .write_mode(write_mode_w), .addr_in(addr_in_w), .data_in(data_in_w),
        .data_out(data_out_w), .busy(busy_w), .done(done_w), .addr_error(addr_error_w), .bus_error(bus_error_w),
        .mem_req(mem_req_w), .mem_we(mem_we_w), .mem_addr(mem_addr_w), .mem_mask(mem_mask_w),
        .mem_wdata(mem_wdata_w), .mem_gnt(mem_gnt_w), .mem_rvalid(mem_rvalid_w), .mem_rdata(mem_rdata_w)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  mode;
        logic [31:0] addr;
        logic [31:0] d;
        logic [31:0] r;
        int          gdly;
        int          rdly;
        logic        exp_err;
        logic [31:0] exp_dout;
        logic [3:0]  exp_mask;
        logic [31:0] exp_wdata;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ref_err(input logic wr, input logic [2:0] mode, input int idx);
        if (wr) begin
            case (mode)
                3'd0, 3'd3, 3'd4: return 1'b0;
                3'd1:             return (idx % 2) != 0;
                3'd2:             return idx != 0;
                default:          return 1'b1;
            endcase
        end
        case (mode)
            3'd0, 3'd4, 3'd5: return 1'b0;
            3'd1, 3'd2:       return (idx % 2) != 0;
            3'd3:             return idx != 0;
            default:          return 1'b1;
        endcase
    endfunction

    function automatic logic [63:0] ref_read(input int nb, input logic [2:0] mode, input int idx,
                                             input logic [63:0] d, input logic [63:0] r);
        logic [7:0]  ob [8];
        logic [7:0]  fill;
        logic [63:0] res;
        for (int k = 0; k < 8; k++) ob[k] = 8'h00;
        case (mode)
            3'd0: begin
                ob[0] = r[8*idx +: 8];
                fill  = ob[0][7] ? 8'hFF : 8'h00;
                for (int k = 1; k < nb; k++) ob[k] = fill;
            end
            3'd1, 3'd2: begin
                ob[0] = r[8*idx +: 8];
                ob[1] = r[8*idx+8 +: 8];
                fill  = (mode == 3'd1 && ob[1][7]) ? 8'hFF : 8'h00;
                for (int k = 2; k < nb; k++) ob[k] = fill;
            end
            3'd3: for (int k = 0; k < nb; k++) ob[k] = r[8*k +: 8];
            3'd4: for (int k = 0; k < nb; k++)
                      ob[k] = (k >= nb-1-idx) ? r[8*(k-(nb-1-idx)) +: 8] : d[8*k +: 8];
            3'd5: for (int k = 0; k < nb; k++)
                      ob[k] = (k < nb-idx) ? r[8*(k+idx) +: 8] : d[8*k +: 8];
            default: ;
        endcase
        res = '0;
        for (int k = 0; k < 8; k++) res[8*k +: 8] = ob[k];
        return res;
    endfunction

    task automatic ref_write(input int nb, input logic [2:0] mode, input int idx, input logic [63:0] d,
                             output logic [7:0] mask, output logic [63:0] wd);
        mask = '0;
        wd   = '0;
        for (int k = 0; k < nb; k++) begin
            case (mode)
                3'd0: begin mask[k] = (k == idx); wd[8*k +: 8] = d[7:0]; end
                3'd1: begin mask[k] = (k == idx) || (k == idx+1); wd[8*k +: 8] = d[8*(k%2) +: 8]; end
                3'd2: begin mask[k] = 1'b1; wd[8*k +: 8] = d[8*k +: 8]; end
                3'd3: if (k <= idx) begin mask[k] = 1'b1; wd[8*k +: 8] = d[8*(k+nb-1-idx) +: 8]; end
                3'd4: if (k >= idx) begin mask[k] = 1'b1; wd[8*k +: 8] = d[8*(k-idx) +: 8]; end
                default: ;
            endcase
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        start      = 1'b1;
        write_mem  = v.wr;
        read_mem   = v.wr ? 1'($urandom % 2) : 1'b1;
        read_mode  = selector::mem_read_type'(v.mode);
        write_mode = selector::mem_write_type'(v.mode);
        addr_in    = v.addr;
        data_in    = v.d;
        @(posedge clk); #1;
        start = 1'b0; read_mem = 1'b0; write_mem = 1'b0;
        if (v.exp_err) begin
            chk("err_done", done, 1'b1);
            chk("err_addr_error", addr_error, 1'b1);
            chk("err_bus_error", bus_error, 1'b0);
            chk("err_no_req", mem_req, 1'b0);
            chk("err_busy", busy, 1'b0);
            chk("err_data_out", data_out, last_dout);
            return;
        end
        for (int i = 0; i <= v.gdly; i++) begin
            chk("req_mem_req", mem_req, 1'b1);
            chk("req_busy", busy, 1'b1);
            chk("req_done", done, 1'b0);
            chk("req_we", mem_we, v.wr);
            chk("req_addr", mem_addr, v.addr >> 2);
            if (v.wr) begin
                chk("req_mask", mem_mask, v.exp_mask);
                chk("req_wdata", mem_wdata, v.exp_wdata);
            end
            mem_gnt    = (i == v.gdly);
            start      = (i < v.gdly);
            read_mem   = 1'b1;
            addr_in    = $urandom;
            mem_rvalid = 1'($urandom % 2);
            mem_rdata  = $urandom;
            @(posedge clk); #1;
        end
        mem_gnt = 1'b0; start = 1'b0; read_mem = 1'b0; mem_rvalid = 1'b0;
        if (!v.wr) begin
            n = (v.rdly < 0) ? TMO : v.rdly + 1;
            for (int j = 0; j < n; j++) begin
                chk("wait_busy", busy, 1'b1);
                chk("wait_done", done, 1'b0);
                chk("wait_req", mem_req, 1'b0);
                mem_rvalid = (j == v.rdly);
                mem_rdata  = (j == v.rdly) ? v.r : $urandom;
                @(posedge clk); #1;
            end
            mem_rvalid = 1'b0;
            if (v.rdly >= 0) last_dout = v.exp_dout;
        end
        chk("fin_done", done, 1'b1);
        chk("fin_busy", busy, 1'b0);
        chk("fin_addr_error", addr_error, 1'b0);
        chk("fin_bus_error", bus_error, (!v.wr && v.rdly < 0));
        chk("fin_data_out", data_out, last_dout);
    endtask

    vec_t vecs [$];
    vec_t v;
    logic [7:0]  m8;
    logic [63:0] w64, d64, r64;
    int          idx;

    initial begin
        reset = 1'b1;
        start = 0; read_mem = 0; write_mem = 0; addr_in = 0; data_in = 0;
        read_mode = selector::RD_BYTE; write_mode = selector::WR_BYTE;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        start_w = 0; read_mem_w = 0; write_mem_w = 0; addr_in_w = 0; data_in_w = 0;
        read_mode_w = selector::RD_BYTE; write_mode_w = selector::WR_BYTE;
        mem_gnt_w = 0; mem_rvalid_w = 0; mem_rdata_w = 0;
        last_dout = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mask", mem_mask, 4'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        //        wr    mode  addr          d             r             g  r   err   dout          mask   wdata
        vecs.push_back('{1'b0, 3'd4, 32'h0000_1001, 32'h1122_3344, 32'hAABB_CCDD, 0, 2, 1'b0, 32'hCCDD_3344, 4'h0, 32'h0});
        vecs.push_back('{1'b1, 3'd4, 32'h0000_2002, 32'h1122_3344, 32'h0,         4, 0, 1'b0, 32'h0,         4'hC, 32'h3344_0000});
        vecs.push_back('{1'b0, 3'd0, 32'h0000_0003, 32'h0,         32'h80FF_FFFF, 1, 0, 1'b0, 32'hFFFF_FF80, 4'h0, 32'h0});
        vecs.push_back('{1'b0, 3'd2, 32'h0000_0002, 32'h0,         32'h8001_0000, 0, 1, 1'b0, 32'h0000_8001, 4'h0, 32'h0});
        vecs.push_back('{1'b0, 3'd3, 32'h0000_0006, 32'h0,         32'h0,         0, 0, 1'b1, 32'h0,         4'h0, 32'h0});
        vecs.push_back('{1'b0, 3'd3, 32'h0000_0100, 32'h0,         32'h0,         0, -1, 1'b0, 32'h0,        4'h0, 32'h0});
        vecs.push_back('{1'b1, 3'd0, 32'h0000_0005, 32'h0000_00A5, 32'h0,         1, 0, 1'b0, 32'h0,         4'h2, 32'hA5A5_A5A5});
        vecs.push_back('{1'b1, 3'd1, 32'h0000_0003, 32'h0,         32'h0,         0, 0, 1'b1, 32'h0,         4'h0, 32'h0});
        vecs.push_back('{1'b0, 3'd7, 32'h0000_0000, 32'h0,         32'h0,         0, 0, 1'b1, 32'h0,         4'h0, 32'h0});
        vecs.push_back('{1'b1, 3'd6, 32'h0000_0000, 32'h0,         32'h0,         0, 0, 1'b1, 32'h0,         4'h0, 32'h0});
        vecs.push_back('{1'b1, 3'd3, 32'h0000_0001, 32'h1122_3344, 32'h0,         2, 0, 1'b0, 32'h0,         4'h3, 32'h0000_1122});
        vecs.push_back('{1'b0, 3'd5, 32'h0000_0001, 32'h1122_3344, 32'hAABB_CCDD, 0, 0, 1'b0, 32'h11AA_BBCC, 4'h0, 32'h0});
        vecs.push_back('{1'b0, 3'd1, 32'h0000_0002, 32'h0,         32'h8001_0000, 0, 3, 1'b0, 32'hFFFF_8001, 4'h0, 32'h0});
        vecs.push_back('{1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         3, 0, 1'b0, 32'h0,         4'hF, 32'hDEAD_BEEF});

        for (int i = 0; i < 40; i++) begin
            v.wr   = 1'($urandom % 2);
            v.mode = 3'($urandom % 8);
            v.addr = $urandom;
            v.d    = $urandom;
            v.r    = $urandom;
            v.gdly = $urandom % 3;
            v.rdly = ($urandom % 6 == 0) ? -1 : int'($urandom % 4);
            idx    = int'(v.addr[1:0]);
            v.exp_err = ref_err(v.wr, v.mode, idx);
            ref_write(4, v.mode, idx, {32'h0, v.d}, m8, w64);
            v.exp_mask  = m8[3:0];
            v.exp_wdata = w64[31:0];
            r64 = ref_read(4, v.mode, idx, {32'h0, v.d}, {32'h0, v.r});
            v.exp_dout  = r64[31:0];
            vecs.push_back(v);
        end

        foreach (vecs[i]) run_vec(vecs[i]);
        @(posedge clk); #1;
        chk("idle_done", done, 1'b0);

        // reset while waiting for read data, then a late rvalid
        start = 1'b1; read_mem = 1'b1; read_mode = selector::RD_WORD; addr_in = 32'h40;
        @(posedge clk); #1;
        start = 1'b0; read_mem = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        chk("rstw_busy_before", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("rstw_mem_req", mem_req, 1'b0);
        chk("rstw_busy", busy, 1'b0);
        chk("rstw_done", done, 1'b0);
        chk("rstw_data_out", data_out, 32'h0);
        chk("rstw_mem_addr", mem_addr, 30'h0);
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        chk("rstw_late_done", done, 1'b0);
        chk("rstw_late_data", data_out, 32'h0);
        last_dout = 32'h0;

        // 64-bit instance: LWR at lane 3 repeatedly, interleaved with LWL at random lanes
        for (int k = 0; k < 8; k++) begin
            d64 = {$urandom, $urandom};
            r64 = {$urandom, $urandom};
            idx = (k % 2 == 0) ? 3 : int'($urandom % 8);
            start_w = 1'b1; read_mem_w = 1'b1;
            read_mode_w = (k % 2 == 0) ? selector::RD_LWR : selector::RD_LWL;
            addr_in_w = {$urandom, $urandom};
            addr_in_w[2:0] = 3'(idx);
            data_in_w = d64;
            @(posedge clk); #1;
            start_w = 1'b0; read_mem_w = 1'b0;
            chk("w64_req", mem_req_w, 1'b1);
            chk("w64_addr", mem_addr_w, addr_in_w >> 3);
            mem_gnt_w = 1'b1;
            @(posedge clk); #1;
            mem_gnt_w = 1'b0;
            chk("w64_busy", busy_w, 1'b1);
            mem_rvalid_w = 1'b1; mem_rdata_w = r64;
            @(posedge clk); #1;
            mem_rvalid_w = 1'b0;
            chk("w64_done", done_w, 1'b1);
            chk("w64_data", data_out_w, ref_read(8, (k % 2 == 0) ? 3'd5 : 3'd4, idx, d64, r64));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
